// File: rtl/cache_mem_ctrl.sv
// Key/value cache controller: keeps slot keys and valid bits locally and drives
// an external value register bank through one-hot write strobes and read selects.
module cache_mem_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_W       = 16,
  parameter int VAL_W       = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [KEY_W-1:0]                   req_key,
  input  logic [VAL_W-1:0]                   req_value,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic                               resp_hit,
  output logic                               resp_err,
  output logic [VAL_W-1:0]                   resp_value,
  output logic [NUM_ENTRIES-1:0]             mem_write,
  output logic [NUM_ENTRIES-1:0]             mem_select,
  output logic [VAL_W-1:0]                   mem_wdata,
  input  logic [VAL_W-1:0]                   mem_rdata,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {OP_GET = 2'b00, OP_PUT = 2'b01, OP_DEL = 2'b10, OP_RSV = 2'b11} op_t;

  state_t                 state, state_n;
  op_t                    op_q;
  logic [KEY_W-1:0]       key_q;
  logic [VAL_W-1:0]       val_q;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [KEY_W-1:0]       keys_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       tgt_idx;
  logic                   tgt_new;

  logic                   hit, free_avail;
  logic [IDX_W-1:0]       hit_idx, free_idx;
  logic [OCC_W-1:0]       occ;
  logic [NUM_ENTRIES-1:0] tgt_onehot;

  // Descending scan so the last assignment wins with the lowest matching slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_avail = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && keys_q[i] == key_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_avail = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (req_valid) state_n = LOOKUP;
      LOOKUP: begin
        case (op_q)
          OP_GET:  state_n = hit ? READ : RESP;
          OP_PUT:  state_n = (hit || free_avail) ? WRITE : RESP;
          default: state_n = RESP;
        endcase
      end
      READ:   state_n = RESP;
      WRITE:  state_n = RESP;
      RESP:   if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign tgt_onehot = NUM_ENTRIES'(1) << tgt_idx;
  assign req_ready  = (state == IDLE);
  assign resp_valid = rst_n && (state == RESP);
  assign mem_select = (rst_n && state == READ)  ? tgt_onehot : '0;
  assign mem_write  = (rst_n && state == WRITE) ? tgt_onehot : '0;
  assign mem_wdata  = val_q;
  assign occupancy  = occ;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_GET;
      key_q      <= '0;
      val_q      <= '0;
      valid_q    <= '0;
      tgt_idx    <= '0;
      tgt_new    <= 1'b0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      resp_value <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (req_valid) begin
          op_q  <= op_t'(req_op);
          key_q <= req_key;
          val_q <= req_value;
        end
        LOOKUP: begin
          resp_hit   <= 1'b0;
          resp_err   <= 1'b0;
          resp_value <= '0;
          tgt_new    <= 1'b0;
          case (op_q)
            OP_GET: begin
              resp_hit <= hit;
              tgt_idx  <= hit_idx;
            end
            OP_PUT: begin
              if (hit) begin
                resp_hit <= 1'b1;
                tgt_idx  <= hit_idx;
              end else if (free_avail) begin
                tgt_idx <= free_idx;
                tgt_new <= 1'b1;
              end else begin
                resp_err <= 1'b1;
              end
            end
            OP_DEL: begin
              resp_hit <= hit;
              if (hit) valid_q[hit_idx] <= 1'b0;
            end
            default: resp_err <= 1'b1;
          endcase
        end
        READ:  resp_value <= mem_rdata;
        WRITE: if (tgt_new) valid_q[tgt_idx] <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the key array has no reset; valid bits gate every match, so stale
  // keys are never observed and the storage stays plain flops.
  always_ff @(posedge clk) begin
    if (rst_n && state == WRITE && tgt_new) keys_q[tgt_idx] <= key_q;
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: vector table over a simple value-bank model
// plus hand-written backpressure and mid-operation reset sequences.
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_key;
  logic [31:0] req_value;
  logic        resp_valid, resp_ready, resp_hit, resp_err;
  logic [31:0] resp_value;
  logic [7:0]  mem_write, mem_select;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  cache_mem_ctrl #(.NUM_ENTRIES(8), .KEY_W(16), .VAL_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_err(resp_err), .resp_value(resp_value),
    .mem_write(mem_write), .mem_select(mem_select), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // External value register bank model.
  logic [31:0] bank [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (mem_write[i]) bank[i] <= mem_wdata;
  end
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) if (mem_select[i]) mem_rdata = bank[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_onehot0", 64'($onehot0(mem_write)), 64'd1);
      check("sel_onehot0", 64'($onehot0(mem_select)), 64'd1);
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] key;
    logic [31:0] val;
    logic        hit;
    logic        err;
    logic [31:0] rval;
    logic [7:0]  wr;
    int          lat;
    int          occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] op, input logic [15:0] key, input logic [31:0] val,
                     input logic hit, input logic err, input logic [31:0] rval,
                     input logic [7:0] wr, input int lat, input int occ);
    vec_t v;
    v.op = op; v.key = key; v.val = val; v.hit = hit; v.err = err;
    v.rval = rval; v.wr = wr; v.lat = lat; v.occ = occ;
    vecs.push_back(v);
  endtask

  // Starts and ends just after a falling edge; resp_ready is held at 1.
  task automatic do_req(input logic [1:0] op, input logic [15:0] key, input logic [31:0] val,
                        output int lat, output logic hit, output logic err,
                        output logic [31:0] rv, output logic [7:0] wr_seen,
                        output int wr_cycles, output logic [31:0] wd, output int occ);
    bit got = 0;
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; hit = 0; err = 0; rv = '0; wr_seen = '0; wr_cycles = 0; wd = '0; occ = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (mem_write != 0) begin
        wr_seen |= mem_write;
        wr_cycles++;
        wd = mem_wdata;
      end
      if (resp_valid) begin
        got = 1; lat = c; hit = resp_hit; err = resp_err; rv = resp_value; occ = int'(occupancy);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("resp_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  int          lat, wrc, occ;
  logic        hit, err;
  logic [31:0] rv, wd, p_val;
  logic [7:0]  wrs;
  logic        p_hit, p_err;
  bit          seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_key = '0; req_value = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_select", 64'(mem_select), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_resp_payload", {resp_hit, resp_err, resp_value}, 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    //   op     key       val           hit err rval          wr     lat occ
    add(2'b01, 16'h1234, 32'hDEADBEEF, 0, 0, 32'h0,        8'h01, 3, 1);
    add(2'b00, 16'h1234, 32'h0,        1, 0, 32'hDEADBEEF, 8'h00, 3, 1);
    add(2'b01, 16'h1234, 32'h5,        1, 0, 32'h0,        8'h01, 3, 1);
    add(2'b00, 16'h1234, 32'h0,        1, 0, 32'h5,        8'h00, 3, 1);
    add(2'b10, 16'h1234, 32'h0,        1, 0, 32'h0,        8'h00, 2, 0);
    add(2'b00, 16'h1234, 32'h0,        0, 0, 32'h0,        8'h00, 2, 0);
    add(2'b10, 16'h1234, 32'h0,        0, 0, 32'h0,        8'h00, 2, 0);
    add(2'b11, 16'h1234, 32'h0,        0, 1, 32'h0,        8'h00, 2, 0);
    for (int i = 0; i < 8; i++)
      add(2'b01, 16'hA000 + 16'(i), 32'h100 + 32'(i), 0, 0, 32'h0, 8'(1 << i), 3, i + 1);
    add(2'b01, 16'hBEEF, 32'h1,        0, 1, 32'h0,        8'h00, 2, 8);
    add(2'b00, 16'hA005, 32'h0,        1, 0, 32'h105,      8'h00, 3, 8);
    add(2'b10, 16'hA003, 32'h0,        1, 0, 32'h0,        8'h00, 2, 7);
    add(2'b01, 16'hC000, 32'h77,       0, 0, 32'h0,        8'h08, 3, 8);
    add(2'b00, 16'hC000, 32'h0,        1, 0, 32'h77,       8'h00, 3, 8);
    add(2'b01, 16'hA007, 32'h99,       1, 0, 32'h0,        8'h80, 3, 8);
    add(2'b00, 16'hA007, 32'h0,        1, 0, 32'h99,       8'h00, 3, 8);
    add(2'b00, 16'hBEEF, 32'h0,        0, 0, 32'h0,        8'h00, 2, 8);

    foreach (vecs[i]) begin
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'd1);
      do_req(vecs[i].op, vecs[i].key, vecs[i].val, lat, hit, err, rv, wrs, wrc, wd, occ);
      check($sformatf("v%0d_hit", i), 64'(hit), 64'(vecs[i].hit));
      check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].err));
      check($sformatf("v%0d_value", i), 64'(rv), 64'(vecs[i].rval));
      check($sformatf("v%0d_mem_write", i), 64'(wrs), 64'(vecs[i].wr));
      check($sformatf("v%0d_wr_cycles", i), 64'(wrc), (vecs[i].wr != 0) ? 64'd1 : 64'd0);
      if (vecs[i].wr != 0) check($sformatf("v%0d_wdata", i), 64'(wd), 64'(vecs[i].val));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_occupancy", i), 64'(occ), 64'(vecs[i].occ));
    end

    // Backpressure: GET hit with resp_ready low for 5 cycles.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_key = 16'hA005; req_value = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (resp_valid) seen = 1;
      else @(negedge clk);
    end
    check("bp_resp_seen", 64'(seen), 64'd1);
    p_hit = resp_hit; p_err = resp_err; p_val = resp_value;
    check("bp_payload", {p_hit, p_err, p_val}, {1'b1, 1'b0, 32'h105});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
      check($sformatf("bp%0d_stable", c), {resp_hit, resp_err, resp_value}, {p_hit, p_err, p_val});
      check($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(resp_valid), 64'd0);
    check("bp_release_ready", 64'(req_ready), 64'd1);

    // Reset during WRITE of an overwrite PUT.
    req_valid = 1'b1; req_op = 2'b01; req_key = 16'hA001; req_value = 32'hFACE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rw_in_write", 64'(mem_write), 64'h02);
    rst_n = 1'b0;
    #1;
    check("rw_write_gated", 64'(mem_write), 64'd0);
    @(negedge clk);
    check("rw_occ", 64'(occupancy), 64'd0);
    check("rw_resp_valid", 64'(resp_valid), 64'd0);
    check("rw_mem_write", 64'(mem_write), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rw_noresp%0d", c), 64'(resp_valid), 64'd0);
    end
    check("rw_bank_kept", 64'(bank[1]), 64'h101);
    do_req(2'b00, 16'hA001, 32'h0, lat, hit, err, rv, wrs, wrc, wd, occ);
    check("rw_get_hit", 64'(hit), 64'd0);
    check("rw_get_value", 64'(rv), 64'd0);
    check("rw_get_latency", 64'(lat), 64'd2);
    check("rw_get_occ", 64'(occ), 64'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
